// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, fetches one word at a time over a
// req/ack handshake, holds it for the datapath and halts on an undecoded opcode.
module instruction_fetch #(
  parameter int                   PC_WIDTH    = 16,
  parameter int                   INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter int                   PC_INC      = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   Stall,
  input  logic                   BranchTaken,
  input  logic [PC_WIDTH-1:0]    BranchTarget,
  output logic                   InstrValid,
  output logic [INSTR_WIDTH-1:0] Instr,
  output logic [3:0]             OPCODE,
  output logic [PC_WIDTH-1:0]    PC,
  output logic                   IllegalOp,
  output logic                   Halted,
  output logic [15:0]            RetiredCount
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALT} state_t;

  state_t                 r_state, w_next;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_valid;
  logic [15:0]            r_retired;
  logic                   w_fetch_done, w_consume, w_legal;
  logic [3:0]             w_opcode;

  assign w_opcode     = r_instr[INSTR_WIDTH-1 -: 4];
  assign w_fetch_done = (r_state == S_FETCH) && imem_ack;
  assign w_consume    = (r_state == S_HOLD) && !Stall;

  always_comb begin
    case (w_opcode)
      4'h0, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF: w_legal = 1'b1;
      default:                                  w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    case (r_state)
      S_FETCH: begin
        // Request is masked during Reset so a pending fetch is visibly abandoned.
        imem_req = !Reset;
        if (imem_ack) w_next = S_HOLD;
      end
      S_HOLD:  if (!Stall) w_next = (r_valid && !w_legal) ? S_HALT : S_FETCH;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_retired <= '0;
    end else if (w_fetch_done) begin
      r_instr <= imem_rdata;
      r_valid <= 1'b1;
    end else if (w_consume) begin
      r_retired <= r_retired + 16'd1;
      // An illegal opcode freezes PC/Instr/InstrValid for post-mortem inspection.
      if (w_legal) begin
        r_pc    <= BranchTaken ? BranchTarget : r_pc + PC_WIDTH'(PC_INC);
        r_valid <= 1'b0;
      end
    end
  end

  assign imem_addr    = r_pc;
  assign PC           = r_pc;
  assign Instr        = r_instr;
  assign OPCODE       = w_opcode;
  assign InstrValid   = r_valid;
  assign IllegalOp    = r_valid && !w_legal;
  assign Halted       = (r_state == S_HALT);
  assign RetiredCount = r_retired;

endmodule
